// File: rtl/freq_divider_prog_pkg.sv
// Shared definitions for the programmable frequency divider.
package freq_divider_prog_pkg;

  // Output generation modes selected through mode_in.
  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/freq_divider_prog_mod_counter.sv
// Modulo counter: counts 0..limit while enabled and wraps back to 0.
// Held at 0 while disabled or cleared. Exposes the post-edge count
// so the parent can derive registered outputs without re-computing it.
module freq_divider_prog_mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // A wrap edge is any enabled edge where the count sits at the limit.
  assign wrap = en && (cnt_q == limit);

  // Next count: restart at 0 on wrap, clear or idle, otherwise increment.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || clear || wrap) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next = cnt_d;

endmodule

// File: rtl/freq_divider_prog.sv
// Programmable frequency divider with toggle, pulse and PWM outputs.
// Configuration is written into shadow registers and transferred to the
// active set only at a period boundary (or at once while idle), so a
// reconfiguration never produces a truncated period.
module freq_divider_prog
  import freq_divider_prog_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [1:0]       mode_in,
  output logic             cfg_pending,
  output logic             tc,
  output logic             out
);

  localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] div_act_q,  div_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  mode_e            mode_act_q, mode_act_d;
  logic [WIDTH-1:0] div_sh_q,   div_sh_d;
  logic [WIDTH-1:0] duty_sh_q,  duty_sh_d;
  mode_e            mode_sh_q,  mode_sh_d;
  logic             pending_q,  pending_d;
  logic             out_q,      out_d;
  logic             tc_q,       tc_d;

  logic             wrap;
  logic [WIDTH-1:0] cnt_next;
  logic             apply;
  mode_e            mode_eff;
  logic [WIDTH-1:0] duty_eff;

  // Pending config lands on the next wrap edge, or on the next edge when idle.
  assign apply = pending_q && (wrap || !en);

  freq_divider_prog_mod_counter #(
    .WIDTH (WIDTH)
  ) u_mod_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (apply),
    .limit    (div_act_q),
    .cnt_next (cnt_next),
    .wrap     (wrap)
  );

  // Shadow capture and shadow-to-active transfer; apply uses pre-edge shadow.
  always_comb begin
    div_act_d  = div_act_q;
    duty_act_d = duty_act_q;
    mode_act_d = mode_act_q;
    div_sh_d   = div_sh_q;
    duty_sh_d  = duty_sh_q;
    mode_sh_d  = mode_sh_q;
    pending_d  = pending_q;
    if (apply) begin
      div_act_d  = div_sh_q;
      duty_act_d = duty_sh_q;
      mode_act_d = mode_sh_q;
      pending_d  = 1'b0;
    end
    if (cfg_wr) begin
      div_sh_d  = div_in;
      duty_sh_d = duty_in;
      mode_sh_d = mode_e'(mode_in);
      pending_d = 1'b1;
    end
  end

  // Output generation; on an apply edge the incoming config drives the output.
  always_comb begin
    mode_eff = apply ? mode_sh_q : mode_act_q;
    duty_eff = apply ? duty_sh_q : duty_act_q;
    tc_d     = wrap;
    out_d    = 1'b0;
    if (en) begin
      case (mode_eff)
        MODE_TOGGLE: out_d = (wrap && !apply) ? ~out_q : out_q;
        MODE_PULSE:  out_d = wrap;
        MODE_PWM:    out_d = (cnt_next < duty_eff);
        default:     out_d = 1'b0;
      endcase
    end
  end

  // Active, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_act_q  <= RESET_DIV_W;
      duty_act_q <= '0;
      mode_act_q <= MODE_TOGGLE;
      div_sh_q   <= RESET_DIV_W;
      duty_sh_q  <= '0;
      mode_sh_q  <= MODE_TOGGLE;
      pending_q  <= 1'b0;
      out_q      <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      duty_act_q <= duty_act_d;
      mode_act_q <= mode_act_d;
      div_sh_q   <= div_sh_d;
      duty_sh_q  <= duty_sh_d;
      mode_sh_q  <= mode_sh_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      tc_q       <= tc_d;
    end
  end

  assign cfg_pending = pending_q;
  assign tc          = tc_q;
  assign out         = out_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Scoreboard bench for freq_divider_prog: the driver pushes the expected
// {cfg_pending, tc, out} for each edge; the monitor pops and compares after it.
module tb_freq_divider_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_wr;
  logic [7:0] div_in;
  logic [7:0] duty_in;
  logic [1:0] mode_in;
  logic       cfg_pending;
  logic       tc;
  logic       out;

  typedef struct {
    logic [2:0] exp;
    string      nm;
    int         idx;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    stepn  = 0;

  freq_divider_prog #(
    .WIDTH     (8),
    .RESET_DIV (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .div_in      (div_in),
    .duty_in     (duty_in),
    .mode_in     (mode_in),
    .cfg_pending (cfg_pending),
    .tc          (tc),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input logic en_v, input logic wr_v, input logic eo,
                      input logic et, input logic ep, input string nm);
    item_t it;
    @(negedge clk);
    en     = en_v;
    cfg_wr = wr_v;
    it.exp = {ep, et, eo};
    it.nm  = nm;
    it.idx = stepn;
    stepn++;
    exp_q.push_back(it);
  endtask

  // Monitor: compare after every rising edge that has a queued expectation.
  initial begin
    item_t      mi;
    logic [2:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mi  = exp_q.pop_front();
        got = {cfg_pending, tc, out};
        checks++;
        if (got !== mi.exp) begin
          errors++;
          $display("FAIL %s step %0d: pend/tc/out got %b expected %b",
                   mi.nm, mi.idx, got, mi.exp);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    cfg_wr  = 1'b0;
    div_in  = 8'd0;
    duty_in = 8'd0;
    mode_in = 2'd0;
    #2;
    checks++;
    if ({cfg_pending, tc, out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: pend/tc/out got %b expected 000", {cfg_pending, tc, out});
    end
    @(negedge clk);
    rst = 1'b0;

    // Default TOGGLE, divisor 255: tc every 256 edges, out period 512.
    for (int k = 1; k <= 520; k++)
      step(1'b1, 1'b0, ((k / 256) % 2) == 1, (k % 256) == 0, 1'b0, "reset_toggle");

    // TOGGLE reconfig to div 3 mid-period; applies on edge 768 holding out.
    div_in = 8'd3; duty_in = 8'd0; mode_in = 2'd0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "toggle_cfg_wr");
    for (int k = 522; k <= 767; k++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "toggle_pending");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "toggle_apply_hold");
    for (int k = 769; k <= 800; k++)
      step(1'b1, 1'b0, (((k - 768) / 4) % 2) == 1, ((k - 768) % 4) == 0, 1'b0, "toggle_div3");

    // PULSE, div 4: applies on edge 804, then one pulse every 5 cycles.
    div_in = 8'd4; mode_in = 2'd1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pulse_cfg_wr");
    for (int k = 802; k <= 803; k++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "pulse_pending");
    for (int k = 804; k <= 834; k++)
      step(1'b1, 1'b0, ((k - 804) % 5) == 0, ((k - 804) % 5) == 0, 1'b0, "pulse_div4");

    // PWM, div 9, duty 3: applies on edge 839.
    div_in = 8'd9; duty_in = 8'd3; mode_in = 2'd2;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pwm3_cfg_wr");
    for (int k = 836; k <= 838; k++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "pwm3_pending");
    for (int k = 839; k <= 879; k++)
      step(1'b1, 1'b0, ((k - 839) % 10) < 3, ((k - 839) % 10) == 0, 1'b0, "pwm_duty3");

    // PWM duty 0: old duty runs until edge 889, then constant 0.
    duty_in = 8'd0;
    for (int k = 880; k <= 888; k++)
      step(1'b1, k == 880, ((k - 839) % 10) < 3, 1'b0, 1'b1, "pwm0_pending");
    for (int k = 889; k <= 909; k++)
      step(1'b1, 1'b0, 1'b0, ((k - 889) % 10) == 0, 1'b0, "pwm_duty0");

    // PWM duty 10 (= N): constant 1 after edge 919.
    duty_in = 8'd10;
    for (int k = 910; k <= 918; k++)
      step(1'b1, k == 910, 1'b0, 1'b0, 1'b1, "pwm10_pending");
    for (int k = 919; k <= 939; k++)
      step(1'b1, 1'b0, 1'b1, ((k - 919) % 10) == 0, 1'b0, "pwm_duty10");

    // Back-to-back writes: div 5 then div 2; only div 2 (TOGGLE) applies at 949.
    div_in = 8'd5; duty_in = 8'd0; mode_in = 2'd0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "b2b_first_wr");
    div_in = 8'd2;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "b2b_second_wr");
    for (int k = 942; k <= 948; k++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "b2b_pending");
    for (int k = 949; k <= 954; k++)
      step(1'b1, 1'b0, (((k - 949) / 3) % 2) == 0, ((k - 949) % 3) == 0, 1'b0, "b2b_div2");

    // Write div 4 at edge 955; at its apply edge 958 write div 1.
    div_in = 8'd4;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "wr_then_pending");
    for (int k = 956; k <= 957; k++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "wr_pending");
    div_in = 8'd1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "wr_on_apply_edge");
    for (int k = 959; k <= 962; k++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "div4_second_pending");
    for (int k = 963; k <= 973; k++)
      step(1'b1, 1'b0, (((k - 963) / 2) % 2) == 0, ((k - 963) % 2) == 0, 1'b0, "div1_applied");

    // Enable drop mid-period and restart with a full first period.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "en_pre0");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "en_pre1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "en_pre2");
    for (int k = 977; k <= 979; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "en_idle");
    for (int k = 980; k <= 985; k++)
      step(1'b1, 1'b0, (((k - 979) / 2) % 2) == 1, ((k - 979) % 2) == 0, 1'b0, "en_restart");

    // Config written while idle applies on the next edge; div 0 gives clk/2.
    div_in = 8'd0; mode_in = 2'd0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "idle_cfg_wr");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_apply");
    div_in = 8'd7; mode_in = 2'd1;
    for (int k = 988; k <= 994; k++)
      step(1'b1, k == 994, ((k - 988) % 2) == 0, 1'b1, k == 994, "div0_clk_half");

    // Async reset between edges with a config pending.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({cfg_pending, tc, out} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: pend/tc/out got %b expected 000", {cfg_pending, tc, out});
    end
    @(negedge clk);
    rst    = 1'b0;
    en     = 1'b0;
    cfg_wr = 1'b0;
    for (int x = 1; x <= 300; x++)
      step(1'b1, 1'b0, x >= 256, x == 256, 1'b0, "post_reset_div255");

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_divider_prog.md
Name: freq_divider_prog

Overview:
- Parametrised programmable frequency divider/regulator; successor of the 8-bit fixed-mode toggle divider.
- Generates a derived output from clk in three modes: toggle (50% square), single-cycle pulse, or PWM with programmable duty.
- New configurations are written through a shadow-register interface and applied glitch-free at a period boundary.
- Feeds downstream blocks (LED/PWM drivers, slow-tick consumers) in the frequency regulator subsystem.

Parameters:
- WIDTH, 8, width of the divisor, duty and internal counter.
- RESET_DIV, 255, active divisor after reset; period N = RESET_DIV+1 cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; 0 = idle.
- cfg_wr  input  1  one-cycle strobe; captures div_in, duty_in and mode_in into the shadow registers.
- div_in  input  WIDTH  divisor; period N = div_in+1 clk cycles.
- duty_in  input  WIDTH  PWM high time, in cycles per period.
- mode_in  input  2  0 = TOGGLE, 1 = PULSE, 2 = PWM, 3 = reserved.
- cfg_pending  output  1  shadow config written but not yet applied.
- tc  output  1  registered strobe, high for the one cycle after each wrap edge.
- out  output  1  registered divided output.

Behaviour:
- Reset (async): cnt=0, div_act=RESET_DIV, duty_act=0, mode_act=TOGGLE; all shadow registers equal the active values; out=0, tc=0, cfg_pending=0.
- Counter: while en=1, cnt increments each edge. A wrap edge is an edge where cnt==div_act; on a wrap edge cnt goes to 0. Wrap-around therefore occurs at div_act, never at 2^WIDTH-1 unless div_act equals it.
- div_act=0: every edge is a wrap edge (N=1).
- tc: set to 1 on a wrap edge, otherwise 0.
- TOGGLE: out inverts on every wrap edge. Output period = 2N cycles; div_act=0 gives clk/2.
- PULSE: out=1 on a wrap edge, otherwise 0. One high cycle every N cycles; first pulse follows the N-th edge after enable.
- PWM: out <= (cnt_next < duty_act), where cnt_next is the counter value after the edge. Gives duty_act high cycles per N-cycle period.
- PWM boundaries: duty_act=0 gives constant 0; duty_act>=N gives constant 1.
- Mode 3: out held 0; counter and tc still run.
- Config write: cfg_wr=1 loads the shadow registers and sets cfg_pending=1. A later cfg_wr before apply overwrites the shadow values (last write wins).
- Apply, en=1: on the next wrap edge with cfg_pending=1, the active registers take the shadow values, cnt=0, and cfg_pending clears.
  - In TOGGLE mode, out keeps its level (no runt pulse).
  - tc still fires on that edge.
- Apply, en=0: pending config is applied on the next edge.
- cfg_wr on the same edge as an apply: the apply uses the pre-edge shadow values, the shadow takes the new values, and cfg_pending stays 1.
- en=0 (idle): cnt held at 0, out forced 0, tc=0. When en returns to 1, counting restarts from 0 with a full first period.
- Reset mid-period or mid-pending: all state returns to the reset values immediately, and any pending config is discarded.
- Latency: out and tc are registered, with no combinational path from any input to any output.

Decomposition:
- Shared package: mode constants MODE_TOGGLE=2'd0, MODE_PULSE=2'd1, MODE_PWM=2'd2, MODE_RSVD=2'd3.
- Sub-module mod_counter (WIDTH): modulo counter with en, clear and limit inputs and a wrap output.
- Shadow/apply logic and output generation stay in the top level.

Test Plan:
- Reset defaults: WIDTH=8, en=1 after reset, default TOGGLE, div_act=255 -> out toggles every 256 cycles (period 512); tc high 1 cycle every 256; cfg_pending=0.
- TOGGLE reconfig: cfg_wr div_in=3 mid-period -> cfg_pending=1 until the current period's wrap edge; afterwards out period = 8 cycles, out level unchanged at the apply edge.
- PULSE: mode_in=1, div_in=4, applied -> out high exactly 1 of every 5 cycles, coincident with tc.
- PWM duty boundaries, mode_in=2, div_in=9:
  - duty_in=3 -> out high 3 cycles, low 7, repeating.
  - duty_in=0 -> out constant 0.
  - duty_in=10 -> out constant 1.
- Back-to-back writes: cfg_wr div_in=5, then div_in=2 before apply -> only div_in=2 takes effect. cfg_wr asserted on the apply edge -> cfg_pending stays 1 and the second config applies one period later.
- Enable and async reset: en=0 mid-period -> out=0, cnt=0; en=1 -> full first period from 0. Async rst pulse between clock edges with cfg_pending=1 -> out=0 and cfg_pending=0 immediately, div_act=255.
